cnn_input_loader: RTL and testbench

- Streaming front-end directly upstream of the conv→maxpool accelerator.
- Accepts one ifmap frame (unsigned pixels, raster order) and one signed kernel over two independent valid/ready streams, and holds both in register arrays.
- Drives the accelerator's en until its done returns, then re-arms for the next frame.
- Converts a pixel/weight stream into the parallel 2-D array ports the accelerator consumes.

---
 rtl/cnn_input_loader.sv | 174 +++++++++++++++++
 tb/tb_cnn_input_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_input_loader.sv
// Front-end for the conv/maxpool accelerator: gathers one ifmap frame and one
// kernel over valid/ready streams, then holds them stable while the accelerator runs.
module cnn_input_loader #(
   parameter int IFMAP_HEIGHT  = 8,
   parameter int IFMAP_WIDTH   = 8,
   parameter int KERNEL_HEIGHT = 3,
   parameter int KERNEL_WIDTH  = 3,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         px_valid,
   output logic                         px_ready,
   input  logic [DATA_WIDTH-1:0]        px_data,
   input  logic                         px_last,
   input  logic                         w_valid,
   output logic                         w_ready,
   input  logic signed [DATA_WIDTH-1:0] w_data,
   output logic [DATA_WIDTH-1:0]        ifmap_out   [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1],
   output logic signed [DATA_WIDTH-1:0] weights_out [0:KERNEL_HEIGHT-1][0:KERNEL_WIDTH-1],
   output logic                         acc_en,
   input  logic                         acc_done,
   output logic                         busy,
   output logic                         frame_err,
   output logic [15:0]                  frame_cnt
);

   localparam int PX_N  = IFMAP_HEIGHT * IFMAP_WIDTH;
   localparam int W_N   = KERNEL_HEIGHT * KERNEL_WIDTH;
   localparam int PX_CW = $clog2(PX_N + 1);
   localparam int W_CW  = $clog2(W_N + 1);
   localparam int PX_IW = $clog2(PX_N);
   localparam int W_IW  = $clog2(W_N);

   localparam logic [PX_CW-1:0] PX_FULL = PX_CW'(PX_N);
   localparam logic [PX_CW-1:0] PX_LAST = PX_CW'(PX_N - 1);
   localparam logic [W_CW-1:0]  W_FULL  = W_CW'(W_N);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_RUN,
      ST_RELEASE
   } state_t;

   state_t                        r_state;
   logic [PX_CW-1:0]              r_px_cnt;
   logic [W_CW-1:0]               r_w_cnt;
   logic                          r_px_ready;
   logic                          r_w_ready;
   logic                          r_acc_en;
   logic                          r_busy;
   logic                          r_frame_err;
   logic [15:0]                   r_frame_cnt;
   logic [DATA_WIDTH-1:0]         r_ifmap  [0:PX_N-1];
   logic signed [DATA_WIDTH-1:0]  r_kernel [0:W_N-1];

   logic                          w_px_fire;
   logic                          w_w_fire;
   logic                          w_frame_bad;
   logic [PX_CW-1:0]              w_px_cnt_nxt;
   logic [W_CW-1:0]               w_w_cnt_nxt;
   logic                          w_px_full_nxt;
   logic                          w_w_full_nxt;

   assign w_px_fire   = px_valid & r_px_ready;
   assign w_w_fire    = w_valid & r_w_ready;
   // A frame is well formed only if px_last marks exactly the final raster index.
   assign w_frame_bad = w_px_fire & (px_last != (r_px_cnt == PX_LAST));

   always_comb begin
      // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
      w_px_cnt_nxt = r_px_cnt;
      w_w_cnt_nxt  = r_w_cnt;
      if (w_px_fire) begin
         w_px_cnt_nxt = w_frame_bad ? '0 : r_px_cnt + PX_CW'(1);
      end
      if (w_w_fire) begin
         w_w_cnt_nxt = r_w_cnt + W_CW'(1);
      end
   end

   assign w_px_full_nxt = (w_px_cnt_nxt == PX_FULL);
   assign w_w_full_nxt  = (w_w_cnt_nxt == W_FULL);

   // NOTE: the buffers sit on the async reset because they must read back as zero out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PX_N; i++) r_ifmap[i]  <= '0;
         for (int i = 0; i < W_N; i++)  r_kernel[i] <= '0;
      end else begin
         if (w_px_fire) r_ifmap[r_px_cnt[PX_IW-1:0]] <= px_data;
         if (w_w_fire)  r_kernel[r_w_cnt[W_IW-1:0]]  <= w_data;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_LOAD;
         r_px_cnt    <= '0;
         r_w_cnt     <= '0;
         r_px_ready  <= 1'b0;
         r_w_ready   <= 1'b0;
         r_acc_en    <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            ST_LOAD: begin
               r_px_cnt    <= w_px_cnt_nxt;
               r_w_cnt     <= w_w_cnt_nxt;
               r_frame_err <= w_frame_bad;
               if (w_px_full_nxt && w_w_full_nxt) begin
                  r_state    <= ST_RUN;
                  r_acc_en   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_px_ready <= 1'b0;
                  r_w_ready  <= 1'b0;
               end else begin
                  r_px_ready <= ~w_px_full_nxt;
                  r_w_ready  <= ~w_w_full_nxt;
               end
            end
            ST_RUN: begin
               if (acc_done) begin
                  r_state     <= ST_RELEASE;
                  r_acc_en    <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
               end
            end
            ST_RELEASE: begin
               // Wait for done to drop so a level-style done is not counted twice.
               if (!acc_done) begin
                  r_state    <= ST_LOAD;
                  r_busy     <= 1'b0;
                  r_px_cnt   <= '0;
                  r_w_cnt    <= '0;
                  r_px_ready <= 1'b1;
                  r_w_ready  <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_LOAD;
               r_acc_en   <= 1'b0;
               r_busy     <= 1'b0;
               r_px_ready <= 1'b0;
               r_w_ready  <= 1'b0;
            end
         endcase
      end
   end

   assign px_ready  = r_px_ready;
   assign w_ready   = r_w_ready;
   assign acc_en    = r_acc_en;
   assign busy      = r_busy;
   assign frame_err = r_frame_err;
   assign frame_cnt = r_frame_cnt;

   for (genvar gr = 0; gr < IFMAP_HEIGHT; gr++) begin : g_px_row
      for (genvar gc = 0; gc < IFMAP_WIDTH; gc++) begin : g_px_col
         assign ifmap_out[gr][gc] = r_ifmap[gr*IFMAP_WIDTH + gc];
      end
   end

   for (genvar gr = 0; gr < KERNEL_HEIGHT; gr++) begin : g_w_row
      for (genvar gc = 0; gc < KERNEL_WIDTH; gc++) begin : g_w_col
         assign weights_out[gr][gc] = r_kernel[gr*KERNEL_WIDTH + gc];
      end
   end

endmodule

// File: tb/tb_cnn_input_loader.sv
// Randomized bench for cnn_input_loader: a scoreboard queue holds each frame/kernel
// the accelerator should see; a monitor compares them when acc_en rises.
module tb_cnn_input_loader;

   localparam int H  = 8;
   localparam int W  = 8;
   localparam int KH = 3;
   localparam int KW = 3;
   localparam int DW = 8;
   localparam int NP = H * W;
   localparam int NW = KH * KW;
   localparam int VW = 512;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 px_valid;
   logic                 px_ready;
   logic [DW-1:0]        px_data;
   logic                 px_last;
   logic                 w_valid;
   logic                 w_ready;
   logic signed [DW-1:0] w_data;
   logic [DW-1:0]        ifmap_out   [0:H-1][0:W-1];
   logic signed [DW-1:0] weights_out [0:KH-1][0:KW-1];
   logic                 acc_en;
   logic                 acc_done;
   logic                 busy;
   logic                 frame_err;
   logic [15:0]          frame_cnt;

   always #5 clk = ~clk;

   cnn_input_loader #(
      .IFMAP_HEIGHT (H),
      .IFMAP_WIDTH  (W),
      .KERNEL_HEIGHT(KH),
      .KERNEL_WIDTH (KW),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .px_valid   (px_valid),
      .px_ready   (px_ready),
      .px_data    (px_data),
      .px_last    (px_last),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_data     (w_data),
      .ifmap_out  (ifmap_out),
      .weights_out(weights_out),
      .acc_en     (acc_en),
      .acc_done   (acc_done),
      .busy       (busy),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: the frame and kernel the accelerator must see, as flat raster vectors.
   logic [NP*DW-1:0] px_q [$];
   logic [NW*DW-1:0] w_q  [$];
   logic [NP*DW-1:0] cur_px;
   logic [NW*DW-1:0] cur_w;
   int               exp_frames = 0;
   int               exp_errs   = 0;
   int               seen_errs  = 0;

   // Monitor: on each acc_en rise, compare presented arrays against the oldest expectation.
   initial begin
      logic             prev_en;
      logic             prev_err;
      logic [NP*DW-1:0] act_p;
      logic [NW*DW-1:0] act_w;
      prev_en  = 1'b0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (acc_en && !prev_en) begin
            if (px_q.size() == 0) begin
               check("unexpected_acc_en", 1, 0);
            end else begin
               for (int r = 0; r < H; r++)
                  for (int c = 0; c < W; c++) act_p[(r*W+c)*DW +: DW] = ifmap_out[r][c];
               for (int r = 0; r < KH; r++)
                  for (int c = 0; c < KW; c++) act_w[(r*KW+c)*DW +: DW] = weights_out[r][c];
               check("ifmap_frame", act_p, px_q.pop_front());
               check("weight_frame", act_w, w_q.pop_front());
            end
         end
         if (frame_err) begin
            seen_errs++;
            if (prev_err) check("frame_err_width", 2, 1);
         end
         prev_en  = acc_en;
         prev_err = frame_err;
      end
   end

   task automatic new_px(input bit rnd);
      for (int k = 0; k < NP; k++) cur_px[k*DW +: DW] = rnd ? DW'($urandom) : DW'(k);
   endtask

   task automatic new_w(input bit rnd);
      for (int k = 0; k < NW; k++) cur_w[k*DW +: DW] = rnd ? DW'($urandom) : DW'(k - 4);
   endtask

   task automatic push_expect();
      px_q.push_back(cur_px);
      w_q.push_back(cur_w);
   endtask

   // Drives pixel beats first..first+n-1 from cur_px; px_last only at index last_at.
   task automatic drive_px(input int first, input int n, input int last_at, input int gap_pct);
      for (int k = first; k < first + n; k++) begin
         int guard;
         while (int'($urandom_range(99)) < gap_pct) begin
            px_valid = 1'b0;
            @(negedge clk);
         end
         px_valid = 1'b1;
         px_data  = cur_px[k*DW +: DW];
         px_last  = (k == last_at);
         guard    = 0;
         while (!px_ready && guard < 300) begin
            @(negedge clk);
            guard++;
         end
         if (!px_ready) begin
            check("px_handshake_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      px_valid = 1'b0;
      px_last  = 1'b0;
   endtask

   task automatic drive_w(input int first, input int n, input int gap_pct);
      for (int k = first; k < first + n; k++) begin
         int guard;
         while (int'($urandom_range(99)) < gap_pct) begin
            w_valid = 1'b0;
            @(negedge clk);
         end
         w_valid = 1'b1;
         w_data  = cur_w[k*DW +: DW];
         guard   = 0;
         while (!w_ready && guard < 300) begin
            @(negedge clk);
            guard++;
         end
         if (!w_ready) begin
            check("w_handshake_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      w_valid = 1'b0;
   endtask

   // Raises acc_done for n cycles and checks the release/re-arm sequence.
   task automatic done_hold(input int n);
      logic hold_bad;
      acc_done = 1'b1;
      @(negedge clk);
      exp_frames++;
      check("acc_en_fall", acc_en, 0);
      check("frame_cnt", frame_cnt, exp_frames);
      hold_bad = 1'b0;
      repeat (n - 1) begin
         if (px_ready || w_ready) hold_bad = 1'b1;
         @(negedge clk);
      end
      if (px_ready || w_ready) hold_bad = 1'b1;
      check("ready_low_while_done", hold_bad, 0);
      acc_done = 1'b0;
      @(negedge clk);
      check("px_ready_rearm", px_ready, 1);
      check("w_ready_rearm", w_ready, 1);
      check("busy_cleared", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] tmp;
      logic          extra;

      rst_n    = 1'b0;
      px_valid = 1'b0;
      px_data  = '0;
      px_last  = 1'b0;
      w_valid  = 1'b0;
      w_data   = '0;
      acc_done = 1'b0;

      // Reset values
      #12;
      check("rst_acc_en", acc_en, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_px_ready", px_ready, 0);
      tmp = ifmap_out[3][5];
      check("rst_ifmap", tmp, 0);
      tmp = weights_out[1][1];
      check("rst_weight", tmp, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("px_ready_after_rst", px_ready, 1);
      check("w_ready_after_rst", w_ready, 1);

      // Nominal frame: pixels 0..63, weights -4..4
      new_px(1'b0);
      new_w(1'b0);
      push_expect();
      fork
         drive_px(0, NP, NP - 1, 0);
         drive_w(0, NW, 0);
      join
      check("nominal_acc_en_latency", acc_en, 1);
      check("nominal_busy", busy, 1);
      check("nominal_px_ready_run", px_ready, 0);
      tmp = ifmap_out[7][7];
      check("ifmap_7_7", tmp, 63);
      tmp = weights_out[0][0];
      check("weight_0_0", tmp, 8'hFC);
      tmp = weights_out[2][2];
      check("weight_2_2", tmp, 8'h04);
      done_hold(5);

      // Early px_last on beat 10, then a full frame is still required
      new_px(1'b1);
      new_w(1'b1);
      fork
         drive_px(0, 11, 10, 0);
         drive_w(0, NW, 0);
      join
      exp_errs++;
      @(negedge clk);
      check("early_last_no_acc_en", acc_en, 0);
      check("early_last_px_ready", px_ready, 1);
      check("early_last_err_seen", seen_errs, exp_errs);
      new_px(1'b1);
      push_expect();
      drive_px(0, NP, NP - 1, 0);
      check("early_last_full_frame_acc_en", acc_en, 1);
      done_hold(1);

      // Missing px_last on beat 63
      new_px(1'b1);
      new_w(1'b1);
      fork
         drive_px(0, NP, -1, 0);
         drive_w(0, NW, 0);
      join
      exp_errs++;
      repeat (5) @(negedge clk);
      check("missing_last_no_acc_en", acc_en, 0);
      check("missing_last_err_seen", seen_errs, exp_errs);
      new_px(1'b1);
      push_expect();
      drive_px(0, NP, NP - 1, 0);
      check("missing_last_recover_acc_en", acc_en, 1);
      done_hold(1);

      // Backpressure and skew: ninth weight arrives 20 cycles after the pixels
      new_px(1'b1);
      new_w(1'b1);
      push_expect();
      fork
         drive_px(0, NP, NP - 1, 40);
         drive_w(0, NW - 1, 30);
      join
      extra    = 1'b0;
      px_valid = 1'b1;
      px_data  = 8'hEE;
      px_last  = 1'b1;
      repeat (20) begin
         if (px_ready) extra = 1'b1;
         @(negedge clk);
      end
      px_valid = 1'b0;
      px_last  = 1'b0;
      check("skew_no_extra_px", extra, 0);
      check("skew_w_ready_waiting", w_ready, 1);
      check("skew_acc_en_before_last_w", acc_en, 0);
      drive_w(NW - 1, 1, 0);
      check("skew_acc_en_after_last_w", acc_en, 1);
      check("skew_w_ready_run", w_ready, 0);
      done_hold(3);

      // Reset asserted mid-RUN
      new_px(1'b1);
      new_w(1'b1);
      push_expect();
      fork
         drive_px(0, NP, NP - 1, 10);
         drive_w(0, NW, 10);
      join
      check("pre_reset_acc_en", acc_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_acc_en", acc_en, 0);
      check("async_rst_frame_cnt", frame_cnt, 0);
      check("async_rst_busy", busy, 0);
      exp_frames = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_px_ready", px_ready, 1);
      new_px(1'b1);
      new_w(1'b1);
      push_expect();
      fork
         drive_px(0, NP, NP - 1, 10);
         drive_w(0, NW, 10);
      join
      check("post_rst_frame_acc_en", acc_en, 1);
      done_hold(1);

      // Back-to-back frames from a clean reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_frames = 0;
      @(negedge clk);
      for (int f = 0; f < 3; f++) begin
         new_px(1'b1);
         new_w(1'b1);
         push_expect();
         fork
            drive_px(0, NP, NP - 1, 20);
            drive_w(0, NW, 20);
         join
         check("b2b_acc_en", acc_en, 1);
         done_hold(1);
      end
      check("b2b_frame_cnt", frame_cnt, 3);

      repeat (3) @(negedge clk);
      check("frame_err_total", seen_errs, exp_errs);
      check("scoreboard_empty", px_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
